// File: rtl/addition_stage5_rounding_if.sv
// Handshake and data bundle for the FP add/sub rounding/pack stage.
// The slave modport is the rounding stage's view; master is the surrounding datapath.
interface addition_stage5_rounding_if #(
  parameter int MENT_WIDTH = 23,
  parameter int EXPO_WIDTH = 8
);
  logic                            in_valid;
  logic                            in_ready;
  logic                            sign_in;
  logic [MENT_WIDTH-1:0]           normalized_mentissa_in;
  logic [EXPO_WIDTH-1:0]           normalized_exponent_in;
  logic [2:0]                      grs_in;
  logic                            zero_in;
  logic                            inf_in;
  logic                            nan_in;
  logic                            out_valid;
  logic                            out_ready;
  logic [EXPO_WIDTH+MENT_WIDTH:0]  result_out;
  logic                            inexact_out;
  logic                            overflow_out;
  logic                            invalid_out;

  modport slave (
    input  in_valid, sign_in, normalized_mentissa_in, normalized_exponent_in,
           grs_in, zero_in, inf_in, nan_in, out_ready,
    output in_ready, out_valid, result_out, inexact_out, overflow_out, invalid_out
  );

  modport master (
    output in_valid, sign_in, normalized_mentissa_in, normalized_exponent_in,
           grs_in, zero_in, inf_in, nan_in, out_ready,
    input  in_ready, out_valid, result_out, inexact_out, overflow_out, invalid_out
  );
endinterface

// File: rtl/addition_stage5_rounding.sv
// FP add/sub stage 5: round-to-nearest-even (stage A) then IEEE-754 pack with
// status flags (stage B), valid/ready on both sides with backpressure.
module addition_stage5_rounding #(
  parameter int MENT_WIDTH = 23,
  parameter int EXPO_WIDTH = 8
) (
  input logic                    clk,
  input logic                    rst_n,
  addition_stage5_rounding_if.slave bus
);
  localparam int RW = 1 + EXPO_WIDTH + MENT_WIDTH;
  localparam logic [EXPO_WIDTH:0] EXP_MAX = {1'b0, {EXPO_WIDTH{1'b1}}};

  logic                  advance_a;
  logic                  advance_b;

  logic                  valid_a;
  logic                  sign_a;
  logic [MENT_WIDTH-1:0] frac_a;
  logic [EXPO_WIDTH:0]   exp_a;
  logic                  inexact_a;
  logic                  zero_a;
  logic                  inf_a;
  logic                  nan_a;

  logic                  round_up;
  logic [MENT_WIDTH:0]   sum;
  logic [MENT_WIDTH-1:0] frac_n;
  logic [EXPO_WIDTH:0]   exp_n;

  logic [RW-1:0]         pk_result;
  logic                  pk_inexact;
  logic                  pk_overflow;
  logic                  pk_invalid;

  assign advance_b   = !bus.out_valid || bus.out_ready;
  assign advance_a   = !valid_a || advance_b;
  assign bus.in_ready = advance_a;

  // Exponent carries one extra bit so a rounding carry into all-ones is visible.
  always_comb begin
    round_up = bus.grs_in[2] & (bus.grs_in[1] | bus.grs_in[0] | bus.normalized_mentissa_in[0]);
    sum      = {1'b0, bus.normalized_mentissa_in} + {{MENT_WIDTH{1'b0}}, round_up};
    if (sum[MENT_WIDTH]) begin
      frac_n = '0;
      exp_n  = {1'b0, bus.normalized_exponent_in} + {{EXPO_WIDTH{1'b0}}, 1'b1};
    end else begin
      frac_n = sum[MENT_WIDTH-1:0];
      exp_n  = {1'b0, bus.normalized_exponent_in};
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      valid_a   <= 1'b0;
      sign_a    <= 1'b0;
      frac_a    <= '0;
      exp_a     <= '0;
      inexact_a <= 1'b0;
      zero_a    <= 1'b0;
      inf_a     <= 1'b0;
      nan_a     <= 1'b0;
    end else if (advance_a) begin
      valid_a   <= bus.in_valid;
      sign_a    <= bus.sign_in;
      frac_a    <= frac_n;
      exp_a     <= exp_n;
      inexact_a <= |bus.grs_in;
      zero_a    <= bus.zero_in;
      inf_a     <= bus.inf_in;
      nan_a     <= bus.nan_in;
    end
  end

  always_comb begin
    pk_result   = '0;
    pk_inexact  = 1'b0;
    pk_overflow = 1'b0;
    pk_invalid  = 1'b0;
    if (nan_a) begin
      pk_result  = {1'b0, {EXPO_WIDTH{1'b1}}, 1'b1, {(MENT_WIDTH-1){1'b0}}};
      pk_invalid = 1'b1;
    end else if (inf_a) begin
      pk_result = {sign_a, {EXPO_WIDTH{1'b1}}, {MENT_WIDTH{1'b0}}};
    end else if (zero_a) begin
      pk_result = {sign_a, {(RW-1){1'b0}}};
    end else if (exp_a >= EXP_MAX) begin
      pk_result   = {sign_a, {EXPO_WIDTH{1'b1}}, {MENT_WIDTH{1'b0}}};
      pk_overflow = 1'b1;
      pk_inexact  = 1'b1;
    end else begin
      pk_result  = {sign_a, exp_a[EXPO_WIDTH-1:0], frac_a};
      pk_inexact = inexact_a;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      bus.out_valid    <= 1'b0;
      bus.result_out   <= '0;
      bus.inexact_out  <= 1'b0;
      bus.overflow_out <= 1'b0;
      bus.invalid_out  <= 1'b0;
    end else if (advance_b) begin
      bus.out_valid    <= valid_a;
      bus.result_out   <= pk_result;
      bus.inexact_out  <= pk_inexact;
      bus.overflow_out <= pk_overflow;
      bus.invalid_out  <= pk_invalid;
    end
  end
endmodule

// File: tb/tb_addition_stage5_rounding.sv
// Self-checking bench for addition_stage5_rounding: directed vectors, backpressure,
// reset behaviour and randomized traffic against an arithmetic reference model.
module tb_addition_stage5_rounding;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  addition_stage5_rounding_if #(.MENT_WIDTH(23), .EXPO_WIDTH(8)) bus ();

  addition_stage5_rounding #(.MENT_WIDTH(23), .EXPO_WIDTH(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct {
    logic        s;
    logic [22:0] m;
    logic [7:0]  e;
    logic [2:0]  g;
    logic        z;
    logic        i;
    logic        n;
  } stim_t;

  int unsigned checks = 0;
  int unsigned fails  = 0;
  logic [34:0] expq[$];
  logic [34:0] pend_exp;
  logic        held_v = 1'b0;
  logic [34:0] held_val;

  // Expected {result, inexact, overflow, invalid} from the rounding rules.
  function automatic logic [34:0] model(input stim_t st);
    int unsigned frac, ex;
    bit up;
    up   = st.g[2] && ((st.g[1:0] != 2'b00) || (st.m % 2 == 1));
    frac = st.m + up;
    ex   = st.e;
    if (frac == (1 << 23)) begin
      frac = 0;
      ex   = ex + 1;
    end
    if (st.n) return {32'h7FC00000, 3'b001};
    if (st.i) return {st.s, 8'hFF, 23'h0, 3'b000};
    if (st.z) return {st.s, 31'h0, 3'b000};
    if (ex >= 255) return {st.s, 8'hFF, 23'h0, 3'b110};
    return {st.s, ex[7:0], frac[22:0], (st.g != 3'b000), 2'b00};
  endfunction

  task automatic chk(input string tag, input logic [34:0] obs, input logic [34:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp_v);
    end
  endtask

  function automatic logic [34:0] observed();
    return {bus.result_out, bus.inexact_out, bus.overflow_out, bus.invalid_out};
  endfunction

  task automatic drive(input stim_t st, input logic [34:0] e);
    bus.sign_in                = st.s;
    bus.normalized_mentissa_in = st.m;
    bus.normalized_exponent_in = st.e;
    bus.grs_in                 = st.g;
    bus.zero_in                = st.z;
    bus.inf_in                 = st.i;
    bus.nan_in                 = st.n;
    pend_exp                   = e;
  endtask

  // One clock: sample at negedge, score output, record acceptance, return at posedge+1.
  task automatic cycle(output bit acc);
    logic [34:0] cur;
    @(negedge clk);
    cur = observed();
    if (held_v) chk("stable_while_stalled", cur, held_val);
    if (bus.out_valid && bus.out_ready) begin
      if (expq.size() == 0) chk("spurious_output", {34'b0, bus.out_valid}, 35'd0);
      else chk("result", cur, expq.pop_front());
    end
    acc = bus.in_valid && bus.in_ready && rst_n;
    if (acc) expq.push_back(pend_exp);
    held_v   = bus.out_valid && !bus.out_ready;
    held_val = cur;
    @(posedge clk);
    #1;
  endtask

  task automatic send(input stim_t st, input logic [34:0] e);
    bit acc = 1'b0;
    drive(st, e);
    bus.in_valid = 1'b1;
    for (int k = 0; k < 50 && !acc; k++) cycle(acc);
    if (!acc) chk("accept_timeout", {34'b0, acc}, 35'd1);
    bus.in_valid = 1'b0;
  endtask

  task automatic drain();
    bit acc;
    bus.in_valid = 1'b0;
    for (int k = 0; k < 40 && expq.size() > 0; k++) cycle(acc);
    chk("drain_empty", 35'(expq.size()), 35'd0);
  endtask

  function automatic stim_t mk(input logic s, input logic [7:0] e, input logic [22:0] m,
                               input logic [2:0] g, input logic z, input logic i, input logic n);
    stim_t st;
    st.s = s; st.e = e; st.m = m; st.g = g; st.z = z; st.i = i; st.n = n;
    return st;
  endfunction

  initial begin
    stim_t st;
    stim_t bp[4];
    bit acc;
    int idx;

    bus.in_valid = 1'b1;
    bus.out_ready = 1'b1;
    drive(mk(0, 8'h7F, 23'h1, 3'b100, 0, 0, 0), 35'd0);

    // Reset held for two edges with in_valid asserted.
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_out_valid", {34'b0, bus.out_valid}, 35'd0);
    chk("reset_outputs", observed(), 35'd0);
    rst_n = 1'b1;
    bus.in_valid = 1'b0;
    #1;
    chk("ready_after_reset", {34'b0, bus.in_ready}, 35'd1);

    // Latency: out_valid rises on the second edge after acceptance.
    drive(mk(0, 8'h7F, 23'h000001, 3'b100, 0, 0, 0), {32'h3F800002, 3'b100});
    bus.in_valid = 1'b1;
    cycle(acc);
    bus.in_valid = 1'b0;
    chk("accept_first", {34'b0, acc}, 35'd1);
    chk("latency_edge1", {34'b0, bus.out_valid}, 35'd0);
    cycle(acc);
    chk("latency_edge2", {34'b0, bus.out_valid}, 35'd1);
    drain();

    // Directed rounding and special cases, back to back.
    send(mk(0, 8'h7F, 23'h000000, 3'b100, 0, 0, 0), {32'h3F800000, 3'b100});
    send(mk(0, 8'h7F, 23'h000000, 3'b000, 0, 0, 0), {32'h3F800000, 3'b000});
    send(mk(0, 8'h7F, 23'h7FFFFF, 3'b101, 0, 0, 0), {32'h40000000, 3'b100});
    send(mk(1, 8'hFE, 23'h7FFFFF, 3'b110, 0, 0, 0), {32'hFF800000, 3'b110});
    send(mk(1, 8'h7F, 23'h000000, 3'b111, 0, 0, 1), {32'h7FC00000, 3'b001});
    send(mk(1, 8'h10, 23'h123456, 3'b101, 0, 1, 0), {32'hFF800000, 3'b000});
    send(mk(1, 8'h10, 23'h123456, 3'b011, 1, 0, 0), {32'h80000000, 3'b000});
    send(mk(0, 8'hFF, 23'h000010, 3'b000, 0, 0, 0), {32'h7F800000, 3'b110});
    send(mk(0, 8'h05, 23'h000000, 3'b000, 1, 1, 1), {32'h7FC00000, 3'b001});
    send(mk(0, 8'h80, 23'h000003, 3'b010, 0, 0, 0), {32'h40000003, 3'b100});
    drain();

    // Backpressure: four back-to-back inputs with out_ready low for five cycles.
    bp[0] = mk(0, 8'h81, 23'h000001, 3'b100, 0, 0, 0);
    bp[1] = mk(1, 8'h82, 23'h000002, 3'b110, 0, 0, 0);
    bp[2] = mk(0, 8'h83, 23'h7FFFFF, 3'b111, 0, 0, 0);
    bp[3] = mk(1, 8'h84, 23'h000004, 3'b001, 0, 0, 0);
    idx = 0;
    for (int cyc = 0; cyc < 30 && (idx < 4 || expq.size() > 0); cyc++) begin
      bus.out_ready = (cyc >= 5);
      bus.in_valid  = (idx < 4);
      if (idx < 4) drive(bp[idx], model(bp[idx]));
      if (cyc == 2) begin
        #1;
        chk("in_ready_drops_when_full", {34'b0, bus.in_ready}, 35'd0);
      end
      cycle(acc);
      if (acc) idx++;
    end
    chk("bp_all_accepted", 35'(idx), 35'd4);
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b1;
    drain();

    // Reset mid-operation discards in-flight data.
    send(mk(0, 8'h40, 23'h000100, 3'b000, 0, 0, 0), {32'h20000100, 3'b000});
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    expq.delete();
    held_v = 1'b0;
    for (int k = 0; k < 4; k++) begin
      cycle(acc);
      chk("no_output_after_reset", {34'b0, bus.out_valid}, 35'd0);
    end

    // Randomized traffic with random gaps and backpressure.
    for (int n = 0; n < 300; n++) begin
      st.s = 1'($urandom);
      st.m = ($urandom_range(0, 3) == 0) ? 23'h7FFFFF : 23'($urandom);
      case ($urandom_range(0, 5))
        0:       st.e = 8'hFE;
        1:       st.e = 8'hFF;
        default: st.e = 8'($urandom);
      endcase
      st.g = 3'($urandom);
      st.z = ($urandom_range(0, 11) == 0);
      st.i = ($urandom_range(0, 11) == 0);
      st.n = ($urandom_range(0, 11) == 0);
      drive(st, model(st));
      bus.in_valid = 1'b1;
      acc = 1'b0;
      for (int k = 0; k < 50 && !acc; k++) begin
        bus.out_ready = ($urandom_range(0, 3) != 0);
        cycle(acc);
      end
      if (!acc) chk("rand_accept_timeout", {34'b0, acc}, 35'd1);
      bus.in_valid = 1'b0;
      if ($urandom_range(0, 3) == 0) begin
        bus.out_ready = 1'($urandom);
        cycle(acc);
      end
    end
    bus.out_ready = 1'b1;
    drain();

    $display("%0d/%0d checks passed", checks - fails, checks);
    $finish;
  end
endmodule
